// File: rtl/pop_count_bcd_display_pkg.sv
// Shared types and constants for the pop-count BCD display stage.
package pop_count_bcd_display_pkg;

  // Conversion FSM states
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoad   = 3'd1,
    StAdjust = 3'd2,
    StShift  = 3'd3,
    StDone   = 3'd4
  } state_e;

  localparam int unsigned BCD_W = 12;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // Double-dabble correction: every nibble >= 5 gets +3, no carry between nibbles
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int n = 0; n < BCD_W / 4; n++) begin
      if (v[n*4 +: 4] >= 4'd5) begin
        r[n*4 +: 4] = v[n*4 +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pop_count_bcd_display_seven_seg_decoder.sv
// One BCD digit to active-low seven-segment pattern, with forced blanking.
module seven_seg_decoder
  import pop_count_bcd_display_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  // Codes 10-15 never come out of the converter; they decode to blank
  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank && (i_digit <= 4'd9)) begin
      o_seg = SEG_DIGIT[i_digit];
    end
  end

endmodule

// File: rtl/pop_count_bcd_display.sv
// Binary count to three BCD digits via sequential double-dabble, shown on
// three active-low seven-segment displays. Last result is held until replaced.
module pop_count_bcd_display
  import pop_count_bcd_display_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,  // 2**WIDTH must not exceed 1000
  parameter int unsigned BLANK_LEADING = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count_in,
  input  logic             count_valid,
  output logic             busy,
  output logic             conv_done,
  output logic [3:0]       bcd_hundreds,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic [6:0]       hex2,
  output logic [6:0]       hex1,
  output logic [6:0]       hex0
);

  localparam int unsigned          CNT_W  = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]     LAST_I = CNT_W'(WIDTH - 1);

  state_e           r_state;
  logic             r_valid_d;
  logic [WIDTH-1:0] r_bin_sr;
  logic [BCD_W-1:0] r_bcd_sr;
  logic [CNT_W-1:0] r_i;
  logic             r_busy;
  logic             r_conv_done;
  logic [3:0]       r_bcd_hund;
  logic [3:0]       r_bcd_tens;
  logic [3:0]       r_bcd_ones;

  logic             w_rise;
  logic             w_blank_hund;
  logic             w_blank_tens;

  // Delay count_valid by one cycle so only its rising edge starts a conversion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_d <= 1'b0;
    end else begin
      r_valid_d <= count_valid;
    end
  end

  assign w_rise = count_valid & ~r_valid_d;

  // Conversion FSM; busy and conv_done are registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_busy      <= 1'b0;
      r_conv_done <= 1'b0;
      r_bin_sr    <= '0;
      r_bcd_sr    <= '0;
      r_i         <= '0;
      r_bcd_hund  <= 4'd0;
      r_bcd_tens  <= 4'd0;
      r_bcd_ones  <= 4'd0;
    end else begin
      r_conv_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          // Edges arriving in any other state are dropped, not queued
          if (w_rise) begin
            r_state <= StLoad;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        StLoad: begin
          r_bin_sr <= count_in;
          r_bcd_sr <= '0;
          r_i      <= '0;
          r_state  <= StAdjust;
          r_busy   <= 1'b1;
        end
        StAdjust: begin
          r_bcd_sr <= bcd_adjust(r_bcd_sr);
          r_state  <= StShift;
          r_busy   <= 1'b1;
        end
        StShift: begin
          {r_bcd_sr, r_bin_sr} <= {r_bcd_sr, r_bin_sr} << 1;
          r_i                  <= r_i + 1'b1;
          r_busy               <= 1'b1;
          if (r_i == LAST_I) begin
            r_state <= StDone;
          end else begin
            r_state <= StAdjust;
          end
        end
        StDone: begin
          r_bcd_hund  <= r_bcd_sr[11:8];
          r_bcd_tens  <= r_bcd_sr[7:4];
          r_bcd_ones  <= r_bcd_sr[3:0];
          r_conv_done <= 1'b1;
          r_state     <= StIdle;
          r_busy      <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign conv_done    = r_conv_done;
  assign bcd_hundreds = r_bcd_hund;
  assign bcd_tens     = r_bcd_tens;
  assign bcd_ones     = r_bcd_ones;

  // Leading-zero suppression; the ones digit always shows
  assign w_blank_hund = (BLANK_LEADING != 0) && (r_bcd_hund == 4'd0);
  assign w_blank_tens = w_blank_hund && (r_bcd_tens == 4'd0);

  seven_seg_decoder u_hex2 (
    .i_digit (r_bcd_hund),
    .i_blank (w_blank_hund),
    .o_seg   (hex2)
  );

  seven_seg_decoder u_hex1 (
    .i_digit (r_bcd_tens),
    .i_blank (w_blank_tens),
    .o_seg   (hex1)
  );

  seven_seg_decoder u_hex0 (
    .i_digit (r_bcd_ones),
    .i_blank (1'b0),
    .o_seg   (hex0)
  );

endmodule

// File: tb/tb_pop_count_bcd_display.sv
// Scoreboard bench for pop_count_bcd_display (WIDTH=8, BLANK_LEADING=1).
module tb_pop_count_bcd_display;

  localparam logic [6:0] BLK = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] count_in;
  logic       count_valid;
  logic       busy;
  logic       conv_done;
  logic [3:0] bcd_hundreds;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic [6:0] hex2;
  logic [6:0] hex1;
  logic [6:0] hex0;

  pop_count_bcd_display #(
    .WIDTH         (8),
    .BLANK_LEADING (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .count_in     (count_in),
    .count_valid  (count_valid),
    .busy         (busy),
    .conv_done    (conv_done),
    .bcd_hundreds (bcd_hundreds),
    .bcd_tens     (bcd_tens),
    .bcd_ones     (bcd_ones),
    .hex2         (hex2),
    .hex1         (hex1),
    .hex0         (hex0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    int         due;
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
    logic [6:0] s2;
    logic [6:0] s1;
    logic [6:0] s0;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Monitor: every conv_done pulse pops one expectation; overdue entries fail
  always @(negedge clk) begin
    if (!rst) begin
      if (conv_done) begin
        if (sb.size() == 0) begin
          check("unexpected_conv_done", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("done_cycle", cyc, mon_e.due);
          check("hundreds", int'(bcd_hundreds), int'(mon_e.h));
          check("tens", int'(bcd_tens), int'(mon_e.t));
          check("ones", int'(bcd_ones), int'(mon_e.o));
          check("hex2", int'(hex2), int'(mon_e.s2));
          check("hex1", int'(hex1), int'(mon_e.s1));
          check("hex0", int'(hex0), int'(mon_e.s0));
          check("busy_at_done", int'(busy), 0);
        end
      end else if (sb.size() != 0 && cyc > sb[0].due) begin
        mon_e = sb.pop_front();
        check("conv_done_timeout", cyc, mon_e.due);
      end
    end
  end

  // Raise count_valid; rise is sampled at the next edge, result 18 edges later
  task automatic start(input logic [7:0] v, input logic [3:0] h, input logic [3:0] t,
                       input logic [3:0] o, input logic [6:0] s2, input logic [6:0] s1,
                       input logic [6:0] s0);
    exp_t e;
    @(negedge clk);
    count_in    = v;
    count_valid = 1'b1;
    e.due = cyc + 19;
    e.h = h; e.t = t; e.o = o;
    e.s2 = s2; e.s1 = s1; e.s0 = s0;
    sb.push_back(e);
    @(negedge clk);
    check("busy_after_rise", int'(busy), 1);
  endtask

  task automatic wait_empty();
    for (int n = 0; n < 60 && sb.size() != 0; n++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic drop_valid();
    @(negedge clk);
    count_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst         = 1'b1;
    count_valid = 1'b0;
    count_in    = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_hex0", int'(hex0), 7'b1000000);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_bcd", int'({bcd_hundreds, bcd_tens, bcd_ones}), 0);
    check("idle_hex0", int'(hex0), 7'b1000000);
    check("idle_hex1", int'(hex1), BLK);
    check("idle_hex2", int'(hex2), BLK);
    check("idle_busy", int'(busy), 0);
    check("idle_conv_done", int'(conv_done), 0);

    // 10 -> 0/1/0
    start(8'd10, 4'd0, 4'd1, 4'd0, BLK, 7'b1111001, 7'b1000000);
    wait_empty();
    drop_valid();

    // 255 -> 2/5/5
    start(8'd255, 4'd2, 4'd5, 4'd5, 7'b0100100, 7'b0010010, 7'b0010010);
    wait_empty();
    drop_valid();

    // 0 -> 0/0/0, leading digits blank
    start(8'd0, 4'd0, 4'd0, 4'd0, BLK, BLK, 7'b1000000);
    wait_empty();
    drop_valid();

    // 7 with a second rising edge and count_in change mid-conversion
    start(8'd7, 4'd0, 4'd0, 4'd7, BLK, BLK, 7'b1111000);
    repeat (4) @(negedge clk);
    count_valid = 1'b0;
    count_in    = 8'd3;
    @(negedge clk);
    count_valid = 1'b1;
    wait_empty();
    repeat (5) @(negedge clk);
    drop_valid();

    // Reset partway through a conversion of 99
    start(8'd99, 4'd0, 4'd9, 4'd9, BLK, 7'b0010000, 7'b0010000);
    repeat (9) @(negedge clk);
    #2;
    rst         = 1'b1;
    count_valid = 1'b0;
    sb.delete();
    #1;
    check("abort_bcd", int'({bcd_hundreds, bcd_tens, bcd_ones}), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_conv_done", int'(conv_done), 0);
    check("abort_hex1", int'(hex1), BLK);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    check("post_abort_bcd", int'({bcd_hundreds, bcd_tens, bcd_ones}), 0);
    start(8'd99, 4'd0, 4'd9, 4'd9, BLK, 7'b0010000, 7'b0010000);
    wait_empty();
    drop_valid();

    // count_valid held high for 50 cycles: one conversion only
    start(8'd4, 4'd0, 4'd0, 4'd4, BLK, BLK, 7'b0011001);
    repeat (50) @(negedge clk);
    count_valid = 1'b0;
    wait_empty();
    repeat (3) @(negedge clk);
    check("final_queue_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

endmodule
